// File: rtl/spi_target.sv
// SPI mode-0 target with byte-addressable RAM, oversampled in the clk domain.
// Protocol: command byte, optional address byte, then streaming data bytes.
module spi_target #(
  parameter int unsigned LGSZ = 8,
  parameter logic [7:0]  ID0  = 8'hEF,
  parameter logic [7:0]  ID1  = 8'h40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            spi_clk,
  input  logic            spi_csn,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  output logic            wr_valid,
  output logic [LGSZ-1:0] wr_addr,
  output logic [7:0]      wr_data,
  input  logic [LGSZ-1:0] host_addr,
  output logic [7:0]      host_rdata
);

  localparam int unsigned DEPTH = 1 << LGSZ;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_RD, DATA_RD, ADDR_WR, DATA_WR, ID, STATUS, IGNORE
  } state_t;

  // Synchroniser and edge-history flops
  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic csn_s1_q, csn_s2_q, csn_h_q;
  logic mosi_s1_q, mosi_s2_q;

  // Protocol state
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      tx_next_q, tx_next_d;
  logic            load_pending_q, load_pending_d;
  logic [LGSZ-1:0] addr_q, addr_d;
  logic [1:0]      id_idx_q, id_idx_d;
  logic            wr_flag_q, wr_flag_d;
  logic            stat_q, stat_d;

  // Registered outputs
  logic            miso_q, miso_d;
  logic            miso_oe_q, miso_oe_d;
  logic            wr_valid_q, wr_valid_d;
  logic [LGSZ-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      host_rdata_q;

  logic [7:0]      mem [0:DEPTH-1];

  logic            sclk_rise, sclk_fall, csn_fall;
  logic [7:0]      rx_byte;
  logic [LGSZ-1:0] rd_addr;
  logic [7:0]      rd_data;
  logic            mem_we;

  assign sclk_rise = sclk_s2_q & ~sclk_h_q;
  assign sclk_fall = ~sclk_s2_q & sclk_h_q;
  assign csn_fall  = ~csn_s2_q & csn_h_q;
  assign rx_byte   = {rx_shift_q, mosi_s2_q};
  // ADDR_RD reads the freshly received address; DATA_RD reads the running pointer
  assign rd_addr   = (state_q == ADDR_RD) ? rx_byte[LGSZ-1:0] : addr_q;
  assign rd_data   = mem[rd_addr];

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk) begin
    sclk_s1_q <= spi_clk;
    sclk_s2_q <= sclk_s1_q;
    sclk_h_q  <= sclk_s2_q;
    csn_s1_q  <= spi_csn;
    csn_s2_q  <= csn_s1_q;
    csn_h_q   <= csn_s2_q;
    mosi_s1_q <= spi_mosi;
    mosi_s2_q <= mosi_s1_q;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      rx_shift_q     <= 7'd0;
      tx_shift_q     <= 8'd0;
      tx_next_q      <= 8'd0;
      load_pending_q <= 1'b0;
      addr_q         <= '0;
      id_idx_q       <= 2'd0;
      wr_flag_q      <= 1'b0;
      stat_q         <= 1'b0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      tx_next_q      <= tx_next_d;
      load_pending_q <= load_pending_d;
      addr_q         <= addr_d;
      id_idx_q       <= id_idx_d;
      wr_flag_q      <= wr_flag_d;
      stat_q         <= stat_d;
      miso_q         <= miso_d;
      miso_oe_q      <= miso_oe_d;
      wr_valid_q     <= wr_valid_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  // Next-state: CSN handling, bit shifting and byte dispatch
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    tx_next_d      = tx_next_q;
    load_pending_d = load_pending_q;
    addr_d         = addr_q;
    id_idx_d       = id_idx_q;
    wr_flag_d      = wr_flag_q;
    stat_d         = stat_q;
    wr_valid_d     = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    mem_we         = 1'b0;
    miso_d         = ~csn_s2_q & tx_shift_q[7];
    miso_oe_d      = ~csn_s2_q;

    if (csn_s2_q) begin
      // Deselected: drop any partial byte, wins over SCLK edges
      state_d        = IDLE;
      bit_cnt_d      = 3'd0;
      tx_shift_d     = 8'd0;
      load_pending_d = 1'b0;
    end else if (csn_fall) begin
      state_d        = CMD;
      bit_cnt_d      = 3'd0;
      tx_shift_d     = 8'd0;
      load_pending_d = 1'b0;
    end else if (state_q != IDLE) begin
      if (sclk_fall) begin
        if (load_pending_q) begin
          tx_shift_d     = tx_next_q;
          load_pending_d = 1'b0;
        end else begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      if (sclk_rise) begin
        rx_shift_d = rx_byte[6:0];
        bit_cnt_d  = 3'(bit_cnt_q + 3'd1);
        if (bit_cnt_q == 3'd7) begin
          load_pending_d = 1'b1;
          tx_next_d      = 8'd0;
          case (state_q)
            CMD: begin
              case (rx_byte)
                8'h03: state_d = ADDR_RD;
                8'h02: state_d = ADDR_WR;
                8'h9F: begin
                  state_d   = ID;
                  tx_next_d = ID0;
                  id_idx_d  = 2'd1;
                end
                8'h05: begin
                  // Status byte is the write flag as it stood at decode
                  state_d   = STATUS;
                  tx_next_d = {7'h0, wr_flag_q};
                  stat_d    = wr_flag_q;
                  wr_flag_d = 1'b0;
                end
                default: state_d = IGNORE;
              endcase
            end
            ADDR_RD: begin
              tx_next_d = rd_data;
              addr_d    = LGSZ'(rd_addr + LGSZ'(1));
              state_d   = DATA_RD;
            end
            DATA_RD: begin
              tx_next_d = rd_data;
              addr_d    = LGSZ'(addr_q + LGSZ'(1));
            end
            ADDR_WR: begin
              addr_d  = rx_byte[LGSZ-1:0];
              state_d = DATA_WR;
            end
            DATA_WR: begin
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = rx_byte;
              wr_flag_d  = 1'b1;
              addr_d     = LGSZ'(addr_q + LGSZ'(1));
            end
            ID: begin
              tx_next_d = (id_idx_q == 2'd1) ? ID1 : 8'd0;
              if (id_idx_q < 2'd2) id_idx_d = 2'(id_idx_q + 2'd1);
            end
            STATUS:  tx_next_d = {7'h0, stat_q};
            default: tx_next_d = 8'd0;
          endcase
        end
      end
    end
  end

  // RAM write port (not cleared by reset)
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[addr_q] <= rx_byte;
  end

  // Host read port, one-cycle latency, old data on a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) host_rdata_q <= 8'd0;
    else       host_rdata_q <= mem[host_addr];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign host_rdata  = host_rdata_q;

endmodule
